// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle FSM issuing fetch/decode/exec/mem/wb control with retire count and illegal-opcode trap
module multicycle_controller #(
  parameter logic [5:0] ADD         = 6'b000001,
  parameter logic [5:0] SUB         = 6'b000010,
  parameter logic [5:0] INC         = 6'b000011,
  parameter logic [5:0] DEC         = 6'b000100,
  parameter logic [5:0] AND         = 6'b000101,
  parameter logic [5:0] OR          = 6'b000110,
  parameter logic [5:0] XOR         = 6'b000111,
  parameter logic [5:0] NOT         = 6'b001000,
  parameter logic [5:0] SHIFT_LEFT  = 6'b001001,
  parameter logic [5:0] SHIFT_RIGHT = 6'b001010,
  parameter logic [5:0] ADDI        = 6'b001011,
  parameter logic [5:0] SUBI        = 6'b001100,
  parameter logic [5:0] LW          = 6'b100010,
  parameter logic [5:0] SW          = 6'b100100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        Imem_Read,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic        Reg_Dst,
  output logic        Reg_Write,
  output logic        Alu_Src,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic        Mem_To_Reg,
  output logic        Shamt_Sel,
  output logic        illegal,
  output logic [3:0]  Alu_Control,
  output logic [2:0]  state,
  output logic [15:0] retired
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
  } state_t;
  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] retired_q, retired_d;
  logic        legal, alu_src, shamt, is_lw, is_sw, is_mem, dp, retire;
  logic [3:0]  alu_c;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 6'd0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  always_comb begin
    legal   = 1'b1;
    alu_c   = 4'b0000;
    alu_src = 1'b0;
    shamt   = 1'b0;
    case (op_q)
      ADD:         alu_c = 4'b0101;
      ADDI:        begin alu_c = 4'b0101; alu_src = 1'b1; end
      SUB:         alu_c = 4'b0110;
      SUBI:        begin alu_c = 4'b0110; alu_src = 1'b1; end
      INC:         alu_c = 4'b0111;
      DEC:         alu_c = 4'b0100;
      AND:         alu_c = 4'b0001;
      OR:          alu_c = 4'b0011;
      XOR:         alu_c = 4'b0010;
      NOT:         alu_c = 4'b0000;
      SHIFT_LEFT:  begin alu_c = 4'b1001; shamt = 1'b1; end
      SHIFT_RIGHT: begin alu_c = 4'b1010; shamt = 1'b1; end
      LW, SW:      begin alu_c = 4'b0101; alu_src = 1'b1; end
      default:     legal = 1'b0;
    endcase
  end
  assign is_lw  = op_q == LW;
  assign is_sw  = op_q == SW;
  assign is_mem = is_lw | is_sw;
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retired_d = retired_q;
    retire    = 1'b0;
    case (state_q)
      IDLE:   state_d = run ? FETCH : IDLE;
      FETCH:  if (imem_ready) begin op_d = opcode; state_d = DECODE; end
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC:   state_d = is_mem ? MEM : WB;
      MEM:    if (dmem_ready) begin state_d = is_lw ? WB : state_q; retire = is_sw; end
      WB:     retire = 1'b1;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
    // run is only honoured at retire, so a dropped run never aborts an instruction
    if (retire) begin
      state_d   = run ? FETCH : IDLE;
      retired_d = retired_q + 16'd1;
    end
  end
  assign dp          = state_q == EXEC || state_q == MEM || state_q == WB;
  assign Imem_Read   = state_q == FETCH;
  assign IR_Write    = Imem_Read & imem_ready;
  assign PC_Write    = Imem_Read & imem_ready;
  assign Reg_Dst     = dp & ~is_mem;
  assign Mem_To_Reg  = dp & ~is_mem;
  assign Alu_Src     = dp & alu_src;
  assign Shamt_Sel   = dp & shamt;
  assign Alu_Control = dp ? alu_c : 4'b0000;
  assign Mem_Read    = state_q == MEM && is_lw;
  assign Mem_Write   = state_q == MEM && is_sw;
  assign Reg_Write   = state_q == WB;
  assign illegal     = state_q == TRAP;
  assign state       = state_q;
  assign retired     = retired_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scenario tasks with hand-computed control vectors per cycle
module tb_multicycle_controller;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic Imem_Read, IR_Write, PC_Write, Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg, Shamt_Sel, illegal;
  logic [3:0] Alu_Control;
  logic [2:0] state;
  logic [15:0] retired;
  logic [14:0] ctl;
  int checks = 0, errors = 0;
  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_D = 3'd2, S_E = 3'd3, S_M = 3'd4, S_W = 3'd5, S_T = 3'd6;
  // ctl = {Imem_Read,IR_Write,PC_Write, Reg_Dst,Reg_Write,Alu_Src, Mem_Write,Mem_Read,Mem_To_Reg, Shamt_Sel,illegal, Alu_Control}
  localparam logic [14:0] C_0     = 15'b000_000_000_00_0000;
  localparam logic [14:0] C_FR    = 15'b111_000_000_00_0000;
  localparam logic [14:0] C_FN    = 15'b100_000_000_00_0000;
  localparam logic [14:0] C_ADDE  = 15'b000_100_001_00_0101;
  localparam logic [14:0] C_ADDW  = 15'b000_110_001_00_0101;
  localparam logic [14:0] C_ADDIE = 15'b000_101_001_00_0101;
  localparam logic [14:0] C_ADDIW = 15'b000_111_001_00_0101;
  localparam logic [14:0] C_MEMX  = 15'b000_001_000_00_0101;
  localparam logic [14:0] C_LWM   = 15'b000_001_010_00_0101;
  localparam logic [14:0] C_LWW   = 15'b000_011_000_00_0101;
  localparam logic [14:0] C_SWM   = 15'b000_001_100_00_0101;
  localparam logic [14:0] C_TRAP  = 15'b000_000_000_01_0000;
  localparam logic [14:0] C_SHLE  = 15'b000_100_001_10_1001;
  localparam logic [14:0] C_SHLW  = 15'b000_110_001_10_1001;
  assign ctl = {Imem_Read, IR_Write, PC_Write, Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg, Shamt_Sel, illegal, Alu_Control};
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .Imem_Read(Imem_Read), .IR_Write(IR_Write), .PC_Write(PC_Write), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
    .Alu_Src(Alu_Src), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .Mem_To_Reg(Mem_To_Reg), .Shamt_Sel(Shamt_Sel),
    .illegal(illegal), .Alu_Control(Alu_Control), .state(state), .retired(retired)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({state, ctl, retired} !== {S_I, C_0, 16'd0}) begin
      errors++;
      $display("FAIL reset: state=%0d ctl=%b retired=%h expected state=0 ctl=%b retired=0000", state, ctl, retired, C_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({state, ctl} !== {S_I, C_0}) begin
      errors++;
      $display("FAIL idle_hold: state=%0d ctl=%b expected state=0 ctl=%b", state, ctl, C_0);
    end
  endtask
  task automatic test_add();
    logic [2:0] es [0:10];
    logic [14:0] ec [0:10];
    logic [15:0] er [0:10];
    logic ir [0:10];
    es = '{S_F, S_D, S_E, S_W, S_F, S_F, S_F, S_D, S_E, S_W, S_I};
    ec = '{C_FR, C_0, C_ADDE, C_ADDW, C_FN, C_FN, C_FR, C_0, C_ADDIE, C_ADDIW, C_0};
    er = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
    ir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    run = 1'b1; opcode = 6'b000001; imem_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      imem_ready = ir[i];
      #1;
      checks++;
      if ({state, ctl, retired} !== {es[i], ec[i], er[i]}) begin
        errors++;
        $display("FAIL add_step%0d: state=%0d ctl=%b retired=%h expected state=%0d ctl=%b retired=%h", i, state, ctl, retired, es[i], ec[i], er[i]);
      end
      if (i == 4) begin run = 1'b0; opcode = 6'b001011; end
    end
  endtask
  task automatic test_lw();
    logic [2:0] es [0:8];
    logic [14:0] ec [0:8];
    logic dr [0:8];
    es = '{S_F, S_D, S_E, S_M, S_M, S_M, S_M, S_W, S_I};
    ec = '{C_FR, C_0, C_MEMX, C_LWM, C_LWM, C_LWM, C_LWM, C_LWW, C_0};
    dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run = 1'b1; opcode = 6'b100010; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      dmem_ready = dr[i];
      #1;
      checks++;
      if ({state, ctl} !== {es[i], ec[i]}) begin
        errors++;
        $display("FAIL lw_step%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
      end
      if (i == 0) run = 1'b0;
      if (i == 1) opcode = 6'b111111;
    end
    checks++;
    if (retired !== 16'd3) begin
      errors++;
      $display("FAIL lw_retired: retired=%h expected 0003", retired);
    end
  endtask
  task automatic test_sw();
    logic [2:0] es [0:5];
    logic [14:0] ec [0:5];
    logic dr [0:5];
    es = '{S_F, S_D, S_E, S_M, S_M, S_I};
    ec = '{C_FR, C_0, C_MEMX, C_SWM, C_SWM, C_0};
    dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run = 1'b1; opcode = 6'b100100; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      dmem_ready = dr[i];
      #1;
      checks++;
      if ({state, ctl} !== {es[i], ec[i]}) begin
        errors++;
        $display("FAIL sw_step%0d: state=%0d ctl=%b expected state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
      end
      if (i == 0) run = 1'b0;
    end
    checks++;
    if (retired !== 16'd4) begin
      errors++;
      $display("FAIL sw_retired: retired=%h expected 0004", retired);
    end
  endtask
  task automatic test_illegal();
    int bad = 0;
    run = 1'b1; opcode = 6'b111111; imem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({state, ctl, retired} !== {S_T, C_TRAP, 16'd4}) begin
      errors++;
      $display("FAIL trap_entry: state=%0d ctl=%b retired=%h expected state=6 ctl=%b retired=0004", state, ctl, retired, C_TRAP);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({state, ctl, retired} !== {S_T, C_TRAP, 16'd4}) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL trap_hold: %0d of 20 cycles left trap, expected 0", bad);
    end
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, ctl, retired} !== {S_I, C_0, 16'd0}) begin
      errors++;
      $display("FAIL trap_reset: state=%0d ctl=%b retired=%h expected state=0 ctl=%b retired=0000", state, ctl, retired, C_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_shift_wrap();
    run = 1'b1; opcode = 6'b001001; imem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({state, ctl} !== {S_E, C_SHLE}) begin
      errors++;
      $display("FAIL shl_exec: state=%0d ctl=%b expected state=3 ctl=%b", state, ctl, C_SHLE);
    end
    run = 1'b0;
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    #1;
    checks++;
    if (retired !== 16'hFFFF) begin
      errors++;
      $display("FAIL shl_preset: retired=%h expected ffff", retired);
    end
    tick();
    checks++;
    if ({state, ctl, retired} !== {S_W, C_SHLW, 16'hFFFF}) begin
      errors++;
      $display("FAIL shl_wb: state=%0d ctl=%b retired=%h expected state=5 ctl=%b retired=ffff", state, ctl, retired, C_SHLW);
    end
    tick();
    checks++;
    if ({state, ctl, retired} !== {S_I, C_0, 16'h0000}) begin
      errors++;
      $display("FAIL shl_wrap: state=%0d ctl=%b retired=%h expected state=0 ctl=%b retired=0000", state, ctl, retired, C_0);
    end
  endtask
  task automatic test_reset_mid_mem();
    bool_wait: begin end
    run = 1'b1; opcode = 6'b100100; imem_ready = 1'b1; dmem_ready = 1'b0;
    tick();
    run = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({state, Mem_Write} !== {S_M, 1'b1}) begin
      errors++;
      $display("FAIL mem_before_reset: state=%0d Mem_Write=%b expected state=4 Mem_Write=1", state, Mem_Write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, ctl} !== {S_I, C_0}) begin
      errors++;
      $display("FAIL async_reset: state=%0d ctl=%b expected state=0 ctl=%b", state, ctl, C_0);
    end
    @(negedge clk);
    run = 1'b1; dmem_ready = 1'b1; rst_n = 1'b1;
    #1;
    checks++;
    if (state !== S_I) begin
      errors++;
      $display("FAIL release_no_move: state=%0d expected 0", state);
    end
    tick();
    checks++;
    if (state !== S_F) begin
      errors++;
      $display("FAIL release_first_edge: state=%0d expected 1", state);
    end
    run = 1'b0;
    for (int i = 0; i < 20 && state !== S_I; i++) tick();
    checks++;
    if ({state, retired} !== {S_I, 16'd1}) begin
      errors++;
      $display("FAIL post_reset_sw: state=%0d retired=%h expected state=0 retired=0001", state, retired);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_illegal();
    test_shift_wrap();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
